// File: rtl/tt_um_univ_shreg_p_if.sv
// Bundle of the universal shift register's control, data and status signals.
// The driver side (master) issues operations; the register (slave) answers.
// Handshake: an operation is accepted on a rising edge where ena=1, the
// register is idle and start=1.  busy is high while steps are in progress.
// done is high for exactly one enabled cycle once the operation is complete.
// The parity signal exists only when SHREG_PARITY_EN is defined.
interface tt_um_univ_shreg_p_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             ena;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] d;
  logic             s_in;
  logic [WIDTH-1:0] q;
  logic             s_out;
  logic             busy;
  logic             done;
`ifdef SHREG_PARITY_EN
  logic             parity;

  modport master (
    output ena, start, mode, amount, d, s_in,
    input  q, s_out, busy, done, parity
  );
  modport slave (
    input  ena, start, mode, amount, d, s_in,
    output q, s_out, busy, done, parity
  );
`else
  modport master (
    output ena, start, mode, amount, d, s_in,
    input  q, s_out, busy, done
  );
  modport slave (
    input  ena, start, mode, amount, d, s_in,
    output q, s_out, busy, done
  );
`endif
endinterface

// File: rtl/tt_um_univ_shreg_p.sv
// Universal shift register with a multi-step sequencer.
// HOLD, LOAD and CLEAR complete in a single edge.  SHL, SHR, ROTL, ROTR and
// ASR run one bit step per enabled edge, for 'amount' steps.
// Optional feature macro: SHREG_PARITY_EN adds a registered parity output
// that carries the XOR of q.
// state_o exposes the FSM state: 0 IDLE, 1 RUN, 2 FIN.
module tt_um_univ_shreg_p #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tt_um_univ_shreg_p_if.slave   bus,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_LOAD  = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             s_out_q, s_out_d;

  // State, counter, latched mode and data registers; ena=0 holds everything
  // because the next-state logic returns the current values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= M_HOLD;
      q_q     <= '0;
      s_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      s_out_q <= s_out_d;
    end
  end

  // Next-state logic: accept in IDLE, one step per edge in RUN, FIN back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = q_q;
    s_out_d = s_out_q;
    if (bus.ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_d = bus.mode;
            case (bus.mode)
              M_HOLD:  state_d = S_FIN;
              M_LOAD: begin
                q_d     = bus.d;
                state_d = S_FIN;
              end
              M_CLEAR: begin
                q_d     = '0;
                state_d = S_FIN;
              end
              default: begin
                // A zero count completes at once with q untouched.
                if (bus.amount != '0) begin
                  cnt_d   = bus.amount;
                  state_d = S_RUN;
                end else begin
                  state_d = S_FIN;
                end
              end
            endcase
          end
        end
        S_RUN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIN;
          case (mode_q)
            M_SHL: begin
              q_d     = {q_q[WIDTH-2:0], bus.s_in};
              s_out_d = q_q[WIDTH-1];
            end
            M_SHR: begin
              q_d     = {bus.s_in, q_q[WIDTH-1:1]};
              s_out_d = q_q[0];
            end
            M_ROTL: begin
              q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              s_out_d = q_q[WIDTH-1];
            end
            M_ROTR: begin
              q_d     = {q_q[0], q_q[WIDTH-1:1]};
              s_out_d = q_q[0];
            end
            M_ASR: begin
              q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
              s_out_d = q_q[0];
            end
            default: begin
              // Single-edge modes never enter RUN.
            end
          endcase
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef SHREG_PARITY_EN
  logic parity_q;

  // Parity tracks q on the same edge; q_d equals q_q when ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^q_d;
  end

  assign bus.parity = parity_q;
`endif

  assign bus.q     = q_q;
  assign bus.s_out = s_out_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_FIN);
  assign state_o   = state_q;

endmodule

// File: tb/tb_tt_um_univ_shreg_p.sv
// Directed bench for tt_um_univ_shreg_p at WIDTH=8.  Inputs change and
// outputs are sampled on the falling clock edge.
module tb_tt_um_univ_shreg_p;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_LOAD  = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  int         n_checks;
  int         n_errors;

  tt_um_univ_shreg_p_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  tt_um_univ_shreg_p #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and follow it to done.  wait_n is the number of
  // falling edges from the start request to the one where done is seen.
  task automatic do_op(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] dd,
                       input logic [31:0] sin_pat, input int stall_at, input bit pulse_start,
                       output int busy_n, output int wait_n, output logic [7:0] stall_q);
    int k;
    int step;
    busy_n  = 0;
    wait_n  = 0;
    stall_q = '0;
    step    = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.amount = amt;
    bus.d      = dd;
    k = 0;
    while (k < 64) begin
      @(negedge clk);
      k++;
      if (k == 1) bus.start = 1'b0;
      if (bus.done) begin
        wait_n = k;
        break;
      end
      if (bus.busy) busy_n++;
      if (step < 32) bus.s_in = sin_pat[step];
      step++;
      if (pulse_start && k == 2) begin
        bus.start = 1'b1;
        bus.mode  = M_CLEAR;
      end
      if (pulse_start && k == 3) bus.start = 1'b0;
      if (k == stall_at) begin
        bus.ena = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (bus.busy) busy_n++;
        end
        stall_q = bus.q;
        bus.ena = 1'b1;
        k += 3;
      end
    end
    if (wait_n == 0) chk("op_timeout", 32'(k), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("back_to_idle", {30'd0, state}, 32'd0);
  endtask

  int         bn;
  int         wn;
  logic [7:0] sq;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.start  = 1'b0;
    bus.mode   = M_HOLD;
    bus.amount = '0;
    bus.d      = '0;
    bus.s_in   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q", {24'd0, bus.q}, 32'h0);
    chk("rst_sout", {31'd0, bus.s_out}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    rst_n = 1'b1;

    // ena low blocks the accept
    bus.ena = 1'b0; bus.start = 1'b1; bus.mode = M_LOAD; bus.d = 8'h5A;
    repeat (2) @(negedge clk);
    chk("ena0_state", {30'd0, state}, 32'd0);
    chk("ena0_q", {24'd0, bus.q}, 32'h0);
    bus.ena = 1'b1; bus.start = 1'b0;

    // LOAD 0x81, ROTL 1 -> 0x03 with s_out 1
    do_op(M_LOAD, 4'd0, 8'h81, 0, -1, 0, bn, wn, sq);
    chk("load_q", {24'd0, bus.q}, 32'h81);
    chk("load_wait", 32'(wn), 32'd1);
    chk("load_busy", 32'(bn), 32'd0);
    do_op(M_ROTL, 4'd1, 8'h00, 0, -1, 0, bn, wn, sq);
    chk("rotl1_q", {24'd0, bus.q}, 32'h03);
    chk("rotl1_sout", {31'd0, bus.s_out}, 32'd1);
    // LOAD keeps s_out
    do_op(M_LOAD, 4'd0, 8'h81, 0, -1, 0, bn, wn, sq);
    chk("load_keeps_sout", {31'd0, bus.s_out}, 32'd1);
`ifdef SHREG_PARITY_EN
    chk("parity_81", {31'd0, bus.parity}, 32'd0);
`endif
    // ROTL 3 from 0x81 -> 0x0C
    do_op(M_ROTL, 4'd3, 8'h00, 0, -1, 0, bn, wn, sq);
    chk("rotl3_q", {24'd0, bus.q}, 32'h0C);
    chk("rotl3_sout", {31'd0, bus.s_out}, 32'd0);
    chk("rotl3_busy", 32'(bn), 32'd3);
    chk("rotl3_wait", 32'(wn), 32'd4);

    // CLEAR, then SHL 8 streaming 1,0,1,0,...
    do_op(M_CLEAR, 4'd5, 8'hFF, 0, -1, 0, bn, wn, sq);
    chk("clear_q", {24'd0, bus.q}, 32'h0);
    chk("clear_wait", 32'(wn), 32'd1);
    do_op(M_SHL, 4'd8, 8'h00, 32'h55, -1, 0, bn, wn, sq);
    chk("shl8_q", {24'd0, bus.q}, 32'hAA);
    chk("shl8_busy", 32'(bn), 32'd8);
    chk("shl8_sout", {31'd0, bus.s_out}, 32'd0);

    // ASR 2 on 0x90 -> 0xE4
    do_op(M_LOAD, 4'd0, 8'h90, 0, -1, 0, bn, wn, sq);
    do_op(M_ASR, 4'd2, 8'h00, 0, -1, 0, bn, wn, sq);
    chk("asr_q", {24'd0, bus.q}, 32'hE4);
    chk("asr_sout", {31'd0, bus.s_out}, 32'd0);

    // HOLD and zero-amount SHR leave q alone
    do_op(M_HOLD, 4'd3, 8'h11, 0, -1, 0, bn, wn, sq);
    chk("hold_q", {24'd0, bus.q}, 32'hE4);
    chk("hold_wait", 32'(wn), 32'd1);
    do_op(M_SHR, 4'd0, 8'h22, 32'hFF, -1, 0, bn, wn, sq);
    chk("shr0_q", {24'd0, bus.q}, 32'hE4);
    chk("shr0_wait", 32'(wn), 32'd1);
    chk("shr0_busy", 32'(bn), 32'd0);

    // ROTR 4 on 0x01 with a 3-cycle stall after the first step
    do_op(M_LOAD, 4'd0, 8'h01, 0, -1, 0, bn, wn, sq);
    do_op(M_ROTR, 4'd4, 8'h00, 0, 2, 0, bn, wn, sq);
    chk("stall_held_q", {24'd0, sq}, 32'h80);
    chk("stall_q", {24'd0, bus.q}, 32'h10);
    chk("stall_wait", 32'(wn), 32'd8);
    chk("stall_busy", 32'(bn), 32'd7);

    // ROTL by more than WIDTH runs the full count
    do_op(M_LOAD, 4'd0, 8'hB4, 0, -1, 0, bn, wn, sq);
    do_op(M_ROTL, 4'd9, 8'h00, 0, -1, 0, bn, wn, sq);
    chk("rotl9_q", {24'd0, bus.q}, 32'h69);
    chk("rotl9_sout", {31'd0, bus.s_out}, 32'd1);
    chk("rotl9_busy", 32'(bn), 32'd9);

    // SHR 3 with fill 1,1,0 and a start pulse (CLEAR) during RUN
    do_op(M_LOAD, 4'd0, 8'h0F, 0, -1, 0, bn, wn, sq);
    do_op(M_SHR, 4'd3, 8'h00, 32'h3, -1, 1, bn, wn, sq);
    chk("shr3_q", {24'd0, bus.q}, 32'h61);
    chk("shr3_sout", {31'd0, bus.s_out}, 32'd1);
    chk("shr3_wait", 32'(wn), 32'd4);

`ifdef SHREG_PARITY_EN
    do_op(M_LOAD, 4'd0, 8'h07, 0, -1, 0, bn, wn, sq);
    chk("parity_07", {31'd0, bus.parity}, 32'd1);
`endif

    // Reset in the middle of SHL 5 aborts without done
    do_op(M_LOAD, 4'd0, 8'h55, 0, -1, 0, bn, wn, sq);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = M_SHL; bus.amount = 4'd5; bus.s_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_q", {24'd0, bus.q}, 32'h0);
    chk("abort_state", {30'd0, state}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bn = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy) bn++;
    end
    chk("abort_no_done", 32'(bn), 32'd0);
    // First enabled edge after release accepts
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; bus.start = 1'b1; bus.mode = M_LOAD; bus.d = 8'h12;
    @(negedge clk);
    bus.start = 1'b0;
    chk("first_accept_q", {24'd0, bus.q}, 32'h12);
    chk("first_accept_done", {31'd0, bus.done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
